// File: rtl/mouse_pos_ctl_if.sv
// Byte-in / cursor-out bundle between the PS/2 byte receiver, mouse_pos_ctl
// and the display pipeline.
interface mouse_pos_ctl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic        mouse_right;
  logic        pkt_valid;
  logic        sync_err;

  modport master (
    output rx_data, rx_valid,
    input  mouse_xpos, mouse_ypos, mouse_left, mouse_right, pkt_valid, sync_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output mouse_xpos, mouse_ypos, mouse_left, mouse_right, pkt_valid, sync_err
  );
endinterface

// File: rtl/mouse_pos_ctl.sv
// Assembles 3-byte PS/2 mouse packets into a clamped absolute cursor position
// and button state; resynchronises framing on a bad header or a stalled packet.
module mouse_pos_ctl #(
  parameter int XMAX    = 799,
  parameter int YMAX    = 599,
  parameter int XINIT   = 400,
  parameter int YINIT   = 300,
  parameter int TIMEOUT = 100000
) (
  input  logic            pclk,
  input  logic            rst_n,
  mouse_pos_ctl_if.slave  bus
);

  localparam int              CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [11:0]     XMAX_C  = 12'(XMAX);
  localparam logic [11:0]     YMAX_C  = 12'(YMAX);
  localparam logic [11:0]     XINIT_C = 12'(XINIT);
  localparam logic [11:0]     YINIT_C = 12'(YINIT);

  typedef enum logic [1:0] {WAIT_B0 = 2'd0, WAIT_B1 = 2'd1, WAIT_B2 = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [5:0]    hdr_q, hdr_d;     // {y_ovf, x_ovf, y_sign, x_sign, right, left}
  logic [7:0]    dx_q, dx_d;
  logic [CW-1:0] idle_q, idle_d;
  logic [11:0]   xpos_q, xpos_d, ypos_q, ypos_d;
  logic          left_q, left_d, right_q, right_d;
  logic          pkt_q, pkt_d, serr_q, serr_d;

  logic signed [13:0] dx_s, dy_s, x_sum_s, y_sum_s;

  function automatic logic [11:0] clamp(input logic signed [13:0] v,
                                        input logic [11:0] max);
    if (v < 14'sd0) begin
      return 12'd0;
    end else if (v > $signed({2'b00, max})) begin
      return max;
    end else begin
      return v[11:0];
    end
  endfunction

  // Delta sign extension, overflow suppression and the unclamped new position.
  always_comb begin
    dx_s    = hdr_q[4] ? 14'sd0 : {{5{hdr_q[2]}}, hdr_q[2], dx_q};
    dy_s    = hdr_q[5] ? 14'sd0 : {{5{hdr_q[3]}}, hdr_q[3], bus.rx_data};
    x_sum_s = $signed({2'b00, xpos_q}) + dx_s;
    // PS/2 reports +y as upward motion, screen y grows downward
    y_sum_s = $signed({2'b00, ypos_q}) - dy_s;
  end

  // Packet framing FSM, idle timeout and output update.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    dx_d    = dx_q;
    idle_d  = '0;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    left_d  = left_q;
    right_d = right_q;
    pkt_d   = 1'b0;
    serr_d  = 1'b0;
    case (state_q)
      WAIT_B0: begin
        if (bus.rx_valid) begin
          if (bus.rx_data[3]) begin
            hdr_d   = {bus.rx_data[7:4], bus.rx_data[1:0]};
            state_d = WAIT_B1;
          end else begin
            serr_d = 1'b1;
          end
        end else begin
          state_d = WAIT_B0;
        end
      end
      WAIT_B1, WAIT_B2: begin
        if (bus.rx_valid) begin
          if (state_q == WAIT_B1) begin
            dx_d    = bus.rx_data;
            state_d = WAIT_B2;
          end else begin
            xpos_d  = clamp(x_sum_s, XMAX_C);
            ypos_d  = clamp(y_sum_s, YMAX_C);
            left_d  = hdr_q[0];
            right_d = hdr_q[1];
            pkt_d   = 1'b1;
            state_d = WAIT_B0;
          end
        end else if (idle_q == TO_LAST) begin
          serr_d  = 1'b1;
          state_d = WAIT_B0;
        end else begin
          idle_d = idle_q + CW'(1);
        end
      end
      default: begin
        state_d = WAIT_B0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_B0;
      hdr_q   <= 6'd0;
      dx_q    <= 8'd0;
      idle_q  <= '0;
      xpos_q  <= XINIT_C;
      ypos_q  <= YINIT_C;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      pkt_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      dx_q    <= dx_d;
      idle_q  <= idle_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      left_q  <= left_d;
      right_q <= right_d;
      pkt_q   <= pkt_d;
      serr_q  <= serr_d;
    end
  end

  assign bus.mouse_xpos  = xpos_q;
  assign bus.mouse_ypos  = ypos_q;
  assign bus.mouse_left  = left_q;
  assign bus.mouse_right = right_q;
  assign bus.pkt_valid   = pkt_q;
  assign bus.sync_err    = serr_q;

endmodule

// File: tb/tb_mouse_pos_ctl.sv
// Scoreboard bench for mouse_pos_ctl: directed packets push expected cursor
// state, a negedge monitor pops and compares on every pkt_valid.
module tb_mouse_pos_ctl;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  mouse_pos_ctl_if bus ();

  mouse_pos_ctl #(
    .XMAX(799), .YMAX(599), .XINIT(400), .YINIT(300), .TIMEOUT(16)
  ) dut (
    .pclk (pclk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        l;
    logic        r;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   serr_seen = 0;
  int   serr_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare on pkt_valid, and require stable outputs otherwise.
  exp_t last;
  logic prev_pkt = 1'b0, prev_serr = 1'b0;
  initial begin
    last = '{x: 12'd400, y: 12'd300, l: 1'b0, r: 1'b0};
    forever begin
      @(negedge pclk);
      if (!rst_n) begin
        last = '{x: 12'd400, y: 12'd300, l: 1'b0, r: 1'b0};
        prev_pkt = 1'b0;
        prev_serr = 1'b0;
      end else begin
        if (bus.sync_err) begin
          serr_seen++;
          check("sync_err_width", {31'd0, prev_serr}, 32'd0);
        end
        if (bus.pkt_valid) begin
          check("pkt_valid_width", {31'd0, prev_pkt}, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_pkt", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("xpos", {20'd0, bus.mouse_xpos}, {20'd0, e.x});
            check("ypos", {20'd0, bus.mouse_ypos}, {20'd0, e.y});
            check("left", {31'd0, bus.mouse_left}, {31'd0, e.l});
            check("right", {31'd0, bus.mouse_right}, {31'd0, e.r});
          end
          last = '{x: bus.mouse_xpos, y: bus.mouse_ypos, l: bus.mouse_left, r: bus.mouse_right};
        end else begin
          check("stable", {6'd0, bus.mouse_xpos, bus.mouse_ypos, bus.mouse_left, bus.mouse_right},
                {6'd0, last.x, last.y, last.l, last.r});
        end
        prev_pkt  = bus.pkt_valid;
        prev_serr = bus.sync_err;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge pclk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic packet(input logic [7:0] h, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [11:0] x, input logic [11:0] y, input logic l, input logic r);
    exp_q.push_back('{x: x, y: y, l: l, r: r});
    send(h);
    send(b1);
    send(b2);
    idle(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    idle(2);
    check("reset_xpos", {20'd0, bus.mouse_xpos}, 32'd400);
    check("reset_ypos", {20'd0, bus.mouse_ypos}, 32'd300);
    check("reset_btn", {30'd0, bus.mouse_left, bus.mouse_right}, 32'd0);
    check("reset_flags", {30'd0, bus.pkt_valid, bus.sync_err}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Basic and negative-delta packets
    packet(8'h09, 8'h0A, 8'h05, 12'd410, 12'd295, 1'b1, 1'b0);
    do_reset();
    packet(8'h3A, 8'hF6, 8'hFB, 12'd390, 12'd305, 1'b0, 1'b1);

    // Clamping in x then y
    do_reset();
    packet(8'h08, 8'hFF, 8'h00, 12'd655, 12'd300, 1'b0, 1'b0);
    packet(8'h08, 8'hFF, 8'h00, 12'd799, 12'd300, 1'b0, 1'b0);
    do_reset();
    packet(8'h08, 8'h00, 8'hFF, 12'd400, 12'd45, 1'b0, 1'b0);
    packet(8'h08, 8'h00, 8'hFF, 12'd400, 12'd0, 1'b0, 1'b0);

    // X overflow suppresses dx only
    do_reset();
    packet(8'h49, 8'h10, 8'h10, 12'd400, 12'd284, 1'b1, 1'b0);

    // Resync after a bad header
    do_reset();
    serr_exp++;
    send(8'h02);
    check("resync_serr", {31'd0, bus.sync_err}, 32'd1);
    packet(8'h08, 8'h01, 8'h00, 12'd401, 12'd300, 1'b0, 1'b0);

    // Timeout fires on the 16th idle cycle
    do_reset();
    serr_exp++;
    send(8'h08);
    idle(15);
    check("timeout_early", {31'd0, bus.sync_err}, 32'd0);
    idle(1);
    check("timeout_serr", {31'd0, bus.sync_err}, 32'd1);
    packet(8'h08, 8'h02, 8'h00, 12'd402, 12'd300, 1'b0, 1'b0);

    // A byte arriving on the last allowed idle cycle is accepted
    send(8'h08);
    idle(15);
    exp_q.push_back('{x: 12'd405, y: 12'd300, l: 1'b0, r: 1'b0});
    send(8'h03);
    idle(15);
    send(8'h00);
    idle(2);

    // Asynchronous reset mid-packet in WAIT_B2
    do_reset();
    packet(8'h09, 8'h0A, 8'h05, 12'd410, 12'd295, 1'b1, 1'b0);
    send(8'h08);
    send(8'h05);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_xpos", {20'd0, bus.mouse_xpos}, 32'd400);
    check("async_ypos", {20'd0, bus.mouse_ypos}, 32'd300);
    check("async_left", {31'd0, bus.mouse_left}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    packet(8'h08, 8'h01, 8'h00, 12'd401, 12'd300, 1'b0, 1'b0);

    idle(3);
    check("sb_drained", exp_q.size(), 32'd0);
    check("serr_count", serr_seen, serr_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
